// File: rtl/game_seq_pkg.sv
// game_seq_pkg: shared play-state encodings and sizing helpers.
// The display and sprite blocks import this package so that every block
// decodes game_status identically (IDLE=0, PLAY=1, DYING=2, OVER=3).
package game_seq_pkg;

    localparam int GAME_STATUS_BIT_LEN = 2;

    typedef enum logic [GAME_STATUS_BIT_LEN-1:0] {
        GS_IDLE  = 2'd0,
        GS_PLAY  = 2'd1,
        GS_DYING = 2'd2,
        GS_OVER  = 2'd3
    } game_state_e;

    // Width of a down-counter that must hold the load value itself; the
    // floor of 2 keeps tiny or zero parameters from collapsing the counter.
    function automatic int cnt_width(input int load_val);
        int floor_val;
        floor_val = (load_val > 2) ? load_val : 2;
        return $clog2(floor_val + 1);
    endfunction

endpackage

// File: rtl/game_seq_sync_edge_det.sv
// sync_edge_det: single-bit edge detector on a synchronous input.
//   clk_i   in  clock, rising edge
//   rst_i   in  synchronous active-high reset
//   sig_i   in  level being watched
//   edge_o  out edge pulse; registered (one cycle late) when REGISTERED=1,
//               otherwise combinational so it acts on the sampling edge
// RST_VAL preloads the history bit so a level already present at reset
// release is not mistaken for an edge.
module sync_edge_det #(
    parameter bit FALLING    = 1'b0,
    parameter bit RST_VAL    = 1'b0,
    parameter bit REGISTERED = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic edge_o
);

    logic sig_q;
    logic edge_q;
    logic edge_s;

    // Edge condition between the current sample and the previous one.
    always_comb begin
        if (FALLING) begin
            edge_s = ~sig_i & sig_q;
        end else begin
            edge_s = sig_i & ~sig_q;
        end
    end

    // History bit and registered pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q  <= RST_VAL;
            edge_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            edge_q <= edge_s;
        end
    end

    assign edge_o = REGISTERED ? edge_q : edge_s;

endmodule

// File: rtl/game_seq.sv
// game_seq: frame-level play-state sequencer (idle / play / dying / over).
//   clk_vga               in  pixel clock
//   rst                   in  synchronous active-high reset
//   v_sync_i              in  vertical sync, active low; falling edge = frame
//   start_btn_i           in  start request level
//   crash_me_enemy_i      in  player/enemy overlap, per pixel
//   crash_enemy_bullet_i  in  bullet/enemy overlap, per pixel
//   game_status_o         out current play state
//   gamestart_o           out one-cycle pulse on IDLE->PLAY
//   obj_rst_o             out one-cycle pulse on IDLE->PLAY and DYING->PLAY
//   frame_tick_o          out one-cycle pulse per frame
//   lives_o               out remaining lives
//   score_o               out score, saturating
//   invincible_o          out high while post-respawn invincibility runs
module game_seq
    import game_seq_pkg::*;
#(
    parameter int LIVES_INIT       = 3,
    parameter int DYING_FRAMES     = 60,
    parameter int INVINC_FRAMES    = 120,
    parameter int OVER_HOLD_FRAMES = 90,
    parameter int SCORE_W          = 16,
    parameter int SCORE_STEP       = 1
) (
    input  logic                           clk_vga,
    input  logic                           rst,
    input  logic                           v_sync_i,
    input  logic                           start_btn_i,
    input  logic                           crash_me_enemy_i,
    input  logic                           crash_enemy_bullet_i,
    output logic [GAME_STATUS_BIT_LEN-1:0] game_status_o,
    output logic                           gamestart_o,
    output logic                           obj_rst_o,
    output logic                           frame_tick_o,
    output logic [1:0]                     lives_o,
    output logic [SCORE_W-1:0]             score_o,
    output logic                           invincible_o
);

    localparam int DYW = cnt_width(DYING_FRAMES);
    localparam int INW = cnt_width(INVINC_FRAMES);
    localparam int OVW = cnt_width(OVER_HOLD_FRAMES);

    localparam logic [DYW-1:0]     DY_LOAD    = DYW'(DYING_FRAMES);
    localparam logic [INW-1:0]     INV_LOAD   = INW'(INVINC_FRAMES);
    localparam logic [OVW-1:0]     HOLD_LOAD  = OVW'(OVER_HOLD_FRAMES);
    localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [SCORE_W-1:0] SCORE_INC  = SCORE_W'(SCORE_STEP);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    game_state_e        state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [DYW-1:0]     dying_q, dying_d;
    logic [INW-1:0]     inv_q, inv_d;
    logic [OVW-1:0]     hold_q, hold_d;
    logic               hit_me_q, hit_me_d;
    logic               hit_blt_q, hit_blt_d;
    logic               gamestart_q, gamestart_d;
    logic               obj_rst_q, obj_rst_d;
    logic               invincible_q;

    logic               frame_tick_s;
    logic               start_edge_s;
    logic [SCORE_W:0]   score_sum_s;

    // Frame boundary: registered falling edge of v_sync.
    sync_edge_det #(
        .FALLING    (1'b1),
        .RST_VAL    (1'b1),
        .REGISTERED (1'b1)
    ) u_vsync_det (
        .clk_i  (clk_vga),
        .rst_i  (rst),
        .sig_i  (v_sync_i),
        .edge_o (frame_tick_s)
    );

    // Start request: rising edge acts on the very edge that samples it.
    sync_edge_det #(
        .FALLING    (1'b0),
        .RST_VAL    (1'b1),
        .REGISTERED (1'b0)
    ) u_start_det (
        .clk_i  (clk_vga),
        .rst_i  (rst),
        .sig_i  (start_btn_i),
        .edge_o (start_edge_s)
    );

    // One extra bit catches overflow so the score saturates instead of wrapping.
    assign score_sum_s = {1'b0, score_q} + {1'b0, SCORE_INC};

    // Next-state logic for the play FSM, counters, score and crash flags.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        dying_d     = dying_q;
        inv_d       = inv_q;
        hold_d      = hold_q;
        gamestart_d = 1'b0;
        obj_rst_d   = 1'b0;

        // Sticky crash flags; a crash on the update edge re-arms the flag
        // for the following frame because set has priority over clear.
        if (state_q != GS_PLAY) begin
            hit_me_d  = 1'b0;
            hit_blt_d = 1'b0;
        end else begin
            hit_me_d  = crash_me_enemy_i     | (hit_me_q  & ~frame_tick_s);
            hit_blt_d = crash_enemy_bullet_i | (hit_blt_q & ~frame_tick_s);
        end

        case (state_q)
            GS_IDLE: begin
                if (start_edge_s) begin
                    state_d     = GS_PLAY;
                    lives_d     = LIVES_LOAD;
                    score_d     = {SCORE_W{1'b0}};
                    inv_d       = {INW{1'b0}};
                    gamestart_d = 1'b1;
                    obj_rst_d   = 1'b1;
                end else begin
                    state_d = GS_IDLE;
                end
            end
            GS_PLAY: begin
                if (frame_tick_s) begin
                    if (hit_blt_q) begin
                        score_d = score_sum_s[SCORE_W] ? SCORE_MAX : score_sum_s[SCORE_W-1:0];
                    end else begin
                        score_d = score_q;
                    end
                    if (inv_q != {INW{1'b0}}) begin
                        inv_d = inv_q - INW'(1);
                    end else if (hit_me_q) begin
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_d = GS_OVER;
                            hold_d  = HOLD_LOAD;
                        end else begin
                            state_d = GS_DYING;
                            dying_d = DY_LOAD;
                        end
                    end else begin
                        inv_d = inv_q;
                    end
                end else begin
                    state_d = GS_PLAY;
                end
            end
            GS_DYING: begin
                if (frame_tick_s) begin
                    // A counter of 1 (or a stray 0) means this update ends DYING.
                    if (dying_q <= DYW'(1)) begin
                        dying_d   = {DYW{1'b0}};
                        state_d   = GS_PLAY;
                        inv_d     = INV_LOAD;
                        obj_rst_d = 1'b1;
                    end else begin
                        dying_d = dying_q - DYW'(1);
                    end
                end else begin
                    state_d = GS_DYING;
                end
            end
            GS_OVER: begin
                if (frame_tick_s && (hold_q != {OVW{1'b0}})) begin
                    hold_d = hold_q - OVW'(1);
                end else begin
                    hold_d = hold_q;
                end
                // Start only counts once the hold has fully expired.
                if (start_edge_s && (hold_q == {OVW{1'b0}})) begin
                    state_d = GS_IDLE;
                end else begin
                    state_d = GS_OVER;
                end
            end
            default: begin
                state_d = GS_IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q      <= GS_IDLE;
            lives_q      <= 2'd0;
            score_q      <= {SCORE_W{1'b0}};
            dying_q      <= {DYW{1'b0}};
            inv_q        <= {INW{1'b0}};
            hold_q       <= {OVW{1'b0}};
            hit_me_q     <= 1'b0;
            hit_blt_q    <= 1'b0;
            gamestart_q  <= 1'b0;
            obj_rst_q    <= 1'b0;
            invincible_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            dying_q      <= dying_d;
            inv_q        <= inv_d;
            hold_q       <= hold_d;
            hit_me_q     <= hit_me_d;
            hit_blt_q    <= hit_blt_d;
            gamestart_q  <= gamestart_d;
            obj_rst_q    <= obj_rst_d;
            invincible_q <= (inv_d != {INW{1'b0}});
        end
    end

    assign game_status_o = state_q;
    assign gamestart_o   = gamestart_q;
    assign obj_rst_o     = obj_rst_q;
    assign frame_tick_o  = frame_tick_s;
    assign lives_o       = lives_q;
    assign score_o       = score_q;
    assign invincible_o  = invincible_q;

endmodule
